// File: rtl/mic1_mem_sequencer.sv
// mic1_mem_sequencer
//   Shares one single-port memory bus between MIC-1 word data accesses
//   (MAR/MDR) and byte instruction fetches (PC/MBR). It inserts wait
//   states for slow memory and aborts accesses that exceed TIMEOUT wait
//   cycles. It also stalls the control path while a transaction is
//   outstanding.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_req/wr_req/fetch_req  microinstruction memory bits, sampled in IDLE only
//   mar, mdr_wdata           word address and write data for data accesses
//   pc                       byte address for fetches
//   mdr_rdata, mdr_load      read word and its one-cycle load pulse
//   mbr_data, mbr_load       fetched byte and its one-cycle load pulse
//   stall                    high while any transaction is outstanding
//   err                      one-cycle pulse on timeout abort or rd+wr conflict
//   mem_*                    memory bus (addr, wdata, strobes, byte select, ready, rdata)
//
// All outputs are registered. A zero-wait access therefore looks like this:
//   sample (cycle 0) -> strobe (cycle 1) -> load pulse (cycle 2).
module mic1_mem_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] mdr_rdata,
  output logic              mdr_load,
  output logic [7:0]        mbr_data,
  output logic              mbr_load,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_byte,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t            state, state_n;
  logic              fetch_pend, fetch_pend_n;
  logic [7:0]        wait_cnt, wait_cnt_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [DATA_W-1:0] mdr_rdata_n, mem_wdata_n;
  logic [7:0]        mbr_data_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              mdr_load_n, mbr_load_n, stall_n, err_n;
  logic              mem_rd_n, mem_wr_n, mem_byte_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pend <= 1'b0;
      wait_cnt   <= '0;
      pc_q       <= '0;
      mdr_rdata  <= '0;
      mdr_load   <= 1'b0;
      mbr_data   <= '0;
      mbr_load   <= 1'b0;
      stall      <= 1'b0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_byte   <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_pend <= fetch_pend_n;
      wait_cnt   <= wait_cnt_n;
      pc_q       <= pc_n;
      mdr_rdata  <= mdr_rdata_n;
      mdr_load   <= mdr_load_n;
      mbr_data   <= mbr_data_n;
      mbr_load   <= mbr_load_n;
      stall      <= stall_n;
      err        <= err_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_rd     <= mem_rd_n;
      mem_wr     <= mem_wr_n;
      mem_byte   <= mem_byte_n;
    end
  end

  always_comb begin
    // hold everything by default; load pulses and err default low
    state_n      = state;
    fetch_pend_n = fetch_pend;
    wait_cnt_n   = wait_cnt;
    pc_n         = pc_q;
    mdr_rdata_n  = mdr_rdata;
    mbr_data_n   = mbr_data;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_rd_n     = mem_rd;
    mem_wr_n     = mem_wr;
    mem_byte_n   = mem_byte;
    stall_n      = stall;
    mdr_load_n   = 1'b0;
    mbr_load_n   = 1'b0;
    err_n        = 1'b0;

    unique case (state)
      IDLE: begin
        if (rd_req || wr_req) begin
          state_n      = DATA;
          wait_cnt_n   = '0;
          mem_addr_n   = {mar[ADDR_W-3:0], 2'b00};
          mem_wdata_n  = mdr_wdata;
          // a rd+wr conflict resolves to the write and is flagged at once
          mem_wr_n     = wr_req;
          mem_rd_n     = ~wr_req;
          mem_byte_n   = 1'b0;
          stall_n      = 1'b1;
          err_n        = rd_req & wr_req;
          fetch_pend_n = fetch_req;
          pc_n         = pc;          // kept for a fetch queued behind the data access
        end else if (fetch_req) begin
          state_n    = FETCH;
          wait_cnt_n = '0;
          mem_addr_n = pc;
          mem_rd_n   = 1'b1;
          mem_wr_n   = 1'b0;
          mem_byte_n = 1'b1;
          stall_n    = 1'b1;
        end
      end

      DATA, FETCH: begin
        if (mem_ready) begin
          if (state == DATA && mem_rd) begin
            mdr_rdata_n = mem_rdata;
            mdr_load_n  = 1'b1;
          end
          if (state == FETCH) begin
            mbr_data_n = mem_rdata[7:0];
            mbr_load_n = 1'b1;
          end
          if (state == DATA && fetch_pend) begin
            // go straight into the queued fetch; stall stays high throughout
            state_n      = FETCH;
            fetch_pend_n = 1'b0;
            wait_cnt_n   = '0;
            mem_addr_n   = pc_q;
            mem_rd_n     = 1'b1;
            mem_wr_n     = 1'b0;
            mem_byte_n   = 1'b1;
          end else begin
            state_n    = IDLE;
            mem_rd_n   = 1'b0;
            mem_wr_n   = 1'b0;
            mem_byte_n = 1'b0;
            stall_n    = 1'b0;
          end
        end else if (wait_cnt == TO_CNT) begin
          // hung access: abort, drop any queued fetch
          state_n      = IDLE;
          fetch_pend_n = 1'b0;
          err_n        = 1'b1;
          mem_rd_n     = 1'b0;
          mem_wr_n     = 1'b0;
          mem_byte_n   = 1'b0;
          stall_n      = 1'b0;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mic1_mem_sequencer.md
Name: mic1_mem_sequencer

Overview:
- Sequences all main-memory traffic for the MIC-1 datapath.
- Accepts the microinstruction memory bits (rd, wr, fetch) and shares one single-port memory bus between word data access (MAR/MDR) and byte instruction fetch (PC/MBR).
- Inserts wait states while the memory is slow, aborts hung accesses by timeout, and stalls the control path (MPC/MIR) while a transaction is outstanding.

Parameters:
- ADDR_W, 32, width of MAR, PC and memory address.
- DATA_W, 32, data word width.
- TIMEOUT, 15, maximum wait cycles without mem_ready before abort; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_req  in  1  microinstruction read bit (word read at MAR)
- wr_req  in  1  microinstruction write bit (word write of MDR at MAR)
- fetch_req  in  1  microinstruction fetch bit (byte read at PC)
- mar  in  ADDR_W  word address for data access
- mdr_wdata  in  DATA_W  MDR value to write
- pc  in  ADDR_W  byte address for fetch
- mdr_rdata  out  DATA_W  read data for MDR
- mdr_load  out  1  one-cycle pulse: load MDR from mdr_rdata
- mbr_data  out  8  fetched byte for MBR
- mbr_load  out  1  one-cycle pulse: load MBR from mbr_data
- stall  out  1  control path and datapath must hold state
- err  out  1  one-cycle pulse: access aborted by timeout or rd+wr conflict
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_byte  out  1  1 = byte access, 0 = word access
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk.
- Reset values: state IDLE, fetch_pend 0, wait counter 0, all strobes, load pulses, stall and err 0, data outputs 0.
- Reset mid-transaction: abandon the access immediately, no load pulse, drop any pending fetch.
- States:
  - IDLE: no transaction outstanding.
  - DATA: word rd or wr outstanding.
  - FETCH: byte fetch outstanding.
- stall = (state != IDLE), registered; high in every DATA/FETCH cycle.
- Requests are sampled only in IDLE. While stall=1 the control path holds MIR, so the held microinstruction's requests are sampled in the first IDLE cycle. Requests presented while stalled are ignored.
- IDLE transitions:
  - rd_req or wr_req → DATA.
  - Only fetch_req → FETCH.
  - If fetch_req accompanies a data request, set fetch_pend=1 (data first).
- rd_req and wr_req both 1: perform the write only, pulse err in the following cycle.
- DATA drive: mem_addr = {mar[ADDR_W-3:0], 2'b00}, mem_byte=0, mem_rd or mem_wr = 1, mem_wdata = mdr_wdata captured at sampling. Address and data are captured at sampling and held stable until completion.
- FETCH drive: mem_addr = pc captured at sampling (for a pending fetch, pc captured in the original IDLE cycle), mem_byte=1, mem_rd=1.
- Completion is a cycle in DATA/FETCH with mem_ready=1. Strobes deassert the next cycle.
  - Read completion: register mem_rdata into mdr_rdata and pulse mdr_load the following cycle.
  - Fetch completion: register mem_rdata[7:0] into mbr_data and pulse mbr_load the following cycle.
  - Write completion: no load pulse.
- After completion: go to FETCH if fetch_pend (clearing it), else IDLE.
- Minimum latency: sample (cycle 0) → strobe (cycle 1, ready=1) → load pulse (cycle 2, state IDLE, stall=0).
- Wait counter:
  - Cleared on entry to DATA/FETCH; increments each cycle with mem_ready=0.
  - On reaching TIMEOUT with mem_ready still 0: abort, no load, pulse err, drop fetch_pend, go to IDLE.
  - mem_ready=1 in the same cycle the count reaches TIMEOUT counts as completion (no err).
- mdr_rdata and mbr_data hold their last loaded values between loads.
- No request in IDLE: strobes 0, stall 0.

Test Plan:
- Read, mem_ready tied 1: rd_req, mar=0x00000010 → cycle 1 mem_rd=1, mem_addr=0x40, mem_byte=0, stall=1; cycle 2 mdr_load=1, mdr_rdata=mem_rdata (0xDEADBEEF), stall=0.
- Write with 3 wait states: wr_req, mar=0x2, mdr_wdata=0x12345678 → mem_wr held 4 cycles, addr 0x8 and data stable, stall 4 cycles, no load pulse, err=0.
- Combined rd+fetch: rd_req=fetch_req=1, pc=0x105 → DATA completes with mdr_load, then FETCH with mem_addr=0x105, mem_byte=1; mbr_load with mbr_data=mem_rdata[7:0]; stall continuous until fetch completes.
- Timeout with TIMEOUT=4 and mem_ready held 0: rd_req → abort after 4 wait cycles, err pulse, no mdr_load, state IDLE; a pending fetch is dropped.
- Conflict and reset: rd_req=wr_req=1 → write only, err pulse; rst asserted mid-DATA → next cycle strobes, stall 0, no load pulse; a new rd after reset behaves as in the first scenario.
